data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 64, byte capacity of the attached data memory; legal doubleword start addresses are 0..MEM_BYTES-8.
REQ-002 Clocking: the block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock shared with the data memory.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 m0_req, m1_req  in  1 each  transaction request from port 0 (pipeline MEM stage) and port 1 (loader/debug).
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read.
REQ-007 m0_addr, m1_addr  in  64 each  byte address of the doubleword.
REQ-008 m0_wdata, m1_wdata  in  64 each  write data, little-endian.
REQ-009 m0_gnt, m1_gnt  out  1 each  acceptance strobe.
REQ-010 m0_rvalid, m1_rvalid  out  1 each  one-cycle completion strobe.
REQ-011 m0_rdata, m1_rdata  out  64 each  read result, valid while the matching rvalid is high.
REQ-012 m0_err, m1_err  out  1 each  out-of-range flag, valid while the matching rvalid is high.
REQ-013 mem_addr, mem_wdata  out  64 each  memory address and write data.
REQ-014 mem_write, mem_read  out  1 each  memory strobes.
REQ-015 mem_rdata  in  64  combinational memory read data.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP, with exactly one transaction outstanding at a time.
REQ-017 In IDLE with any req high, the block SHALL select a winner, assert that port's gnt combinationally in the same cycle, latch its we/addr/wdata at the clock edge, and enter ACCESS.
REQ-018 Arbitration: a single requester SHALL win; when both request, the port not served last SHALL win (round-robin), and the last-served pointer SHALL reset to port 1 so that port 0 wins the first tie.
REQ-019 A requester SHALL hold req/we/addr/wdata stable until its gnt; a req not granted SHALL remain pending, and the block SHALL NOT drop it.
REQ-020 ACCESS SHALL last exactly one cycle: mem_addr/mem_wdata driven from the latched values; mem_write = latched we, mem_read = !latched we; the memory writes on the edge ending ACCESS; mem_rdata captured into a response register at that edge.
REQ-021 RESP SHALL last exactly one cycle: the winner's rvalid is high, rdata = captured data for reads or 0 for writes, and err reflects REQ-023; the pointer updates on exit to IDLE.
REQ-022 Latency: gnt in cycle N, ACCESS in cycle N+1, rvalid in cycle N+2; the next gnt is possible no earlier than N+3, giving a peak of one transaction per 3 cycles.
REQ-023 Range check (unsigned 64-bit): addr > MEM_BYTES-8 SHALL suppress mem_write and mem_read during ACCESS and SHALL return err=1 and rdata=0; the address SHALL NOT wrap.
REQ-024 Misaligned in-range addresses SHALL be legal and passed through unchanged.
REQ-025 Outside ACCESS, mem_write and mem_read SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values; gnt, rvalid and err SHALL be 0 whenever not asserted per REQ-017, REQ-021 and REQ-023.
REQ-026 Requests arriving during ACCESS or RESP SHALL be ignored until the next IDLE cycle; a req may be deasserted the cycle after gnt without effect on the transaction.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, pointer = 1, and all gnt/rvalid/err/mem_write/mem_read = 0, with mem_addr/mem_wdata/rdata registers = 0.
REQ-028 Reset during ACCESS or RESP SHALL abandon the transaction: no rvalid SHALL follow, and a write is suppressed if reset asserts before its clock edge.
REQ-029 After rst_n rises, the first IDLE cycle SHALL arbitrate normally.

Verification
REQ-030 Memory preloaded with byte 3 at address 0: m0 read of addr 0 -> m0_gnt in cycle N, mem_read in N+1, m0_rvalid in N+2 with m0_rdata=64'h3 and m0_err=0.
REQ-031 m1 writes 64'h1122334455667788 to addr 8, then m0 reads addr 8 -> m1_rvalid with rdata=0, then m0_rdata=64'h1122334455667788.
REQ-032 m0_req and m1_req held high continuously from reset -> grant order 0,1,0,1; each gnt is 3 cycles apart; no port is granted twice in a row.
REQ-033 m0 reads addr 57 and m1 writes addr 64'hFFFF_FFFF_FFFF_FFFC -> mem_read and mem_write are never asserted; each rvalid carries err=1 and rdata=0; memory is unchanged.
REQ-034 rst_n pulsed low in the ACCESS cycle of an m1 write to addr 16 -> no m1_rvalid; memory byte 16 keeps its preload value 9; the next m1 request is granted normally.
REQ-035 Misaligned m0 write of 64'hAABB to addr 3 -> bytes 3 and 4 become BB and AA; an m0 read of addr 0 returns 64'h000000AABB000003.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Two-requester data-memory bus: port 0 (pipeline MEM stage), port 1
// (loader/debug), plus the single-port memory side.
interface data_mem_arbiter_if;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m0_err;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          m1_err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  // Requesters and the memory model drive this side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter between two doubleword requesters and one data memory.
// One transaction in flight: IDLE (grant) -> ACCESS (memory cycle) -> RESP.
module data_mem_arbiter #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam logic [AW-1:0] ADDR_MAX = AW'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q;
  logic          win_q;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          rvalid0_q, rvalid1_q;
  logic          err0_q, err1_q;
  logic          mem_write_q, mem_read_q;

  logic          win_c;
  logic          gnt0_c, gnt1_c;
  logic          grant_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          in_range_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, winner selection and same-cycle grant
  always_comb begin
    state_d = state_q;
    win_c   = 1'b0;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    if (bus.m0_req && bus.m1_req) win_c = ~last_q;
    else                          win_c = bus.m1_req;
    case (state_q)
      IDLE: begin
        // Grant is masked while reset is held so nothing looks accepted
        if (rst_n && (bus.m0_req || bus.m1_req)) begin
          gnt0_c  = ~win_c;
          gnt1_c  = win_c;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_c     = gnt0_c | gnt1_c;
  assign sel_we_c    = win_c ? bus.m1_we    : bus.m0_we;
  assign sel_addr_c  = win_c ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata_c = win_c ? bus.m1_wdata : bus.m0_wdata;
  // Unsigned compare against the last legal start; no wrap-around
  assign in_range_c  = (sel_addr_c <= ADDR_MAX);

  // Request latch, memory strobes, response capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            win_q       <= win_c;
            we_q        <= sel_we_c;
            err_q       <= ~in_range_c;
            addr_q      <= sel_addr_c;
            wdata_q     <= sel_wdata_c;
            mem_write_q <= sel_we_c & in_range_c;
            mem_read_q  <= ~sel_we_c & in_range_c;
          end
        end
        ACCESS: begin
          rdata_q   <= (we_q || err_q) ? '0 : bus.mem_rdata;
          rvalid0_q <= ~win_q;
          rvalid1_q <= win_q;
          err0_q    <= ~win_q & err_q;
          err1_q    <= win_q & err_q;
        end
        RESP: last_q <= win_q;
        default: ;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt0_c;
  assign bus.m1_gnt    = gnt1_c;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata_q;
  assign bus.m1_rdata  = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_read  = mem_read_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte-array memory, directed scenarios, then
// randomized single/tied requests checked against a byte-level reference.
module tb_data_mem_arbiter;

  localparam int unsigned MEM_BYTES = 64;
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  logic clk;
  logic rst_n;

  data_mem_arbiter_if bus ();

  data_mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: preload, then write on rising edge when strobed
  logic [7:0] mem [MEM_BYTES];
  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    mem[0]  = 8'h03;
    mem[16] = 8'h09;
    forever begin
      @(posedge clk);
      if (bus.mem_write) begin
        for (int i = 0; i < 8; i++) begin
          if (bus.mem_addr < 64'(MEM_BYTES) && bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
            mem[int'(bus.mem_addr[15:0]) + i] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Combinational read port
  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_addr < 64'(MEM_BYTES) && bus.mem_addr + 64'(i) < 64'(MEM_BYTES))
        bus.mem_rdata[8*i +: 8] = mem[int'(bus.mem_addr[15:0]) + i];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [MEM_BYTES];
  int          last;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [63:0] addr_v  [2];
  logic [63:0] wdata_v [2];

  int n_err;
  int n_checks;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_mem[int'(a[15:0]) + i];
    return v;
  endfunction

  task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) ref_mem[int'(a[15:0]) + i] = d[8*i +: 8];
  endtask

  task automatic apply();
    bus.m0_req   = req_v[0];
    bus.m0_we    = we_v[0];
    bus.m0_addr  = addr_v[0];
    bus.m0_wdata = wdata_v[0];
    bus.m1_req   = req_v[1];
    bus.m1_we    = we_v[1];
    bus.m1_addr  = addr_v[1];
    bus.m1_wdata = wdata_v[1];
  endtask

  task automatic set_req(input int p, input logic we, input logic [63:0] a, input logic [63:0] d);
    req_v[p]   = 1'b1;
    we_v[p]    = we;
    addr_v[p]  = a;
    wdata_v[p] = d;
  endtask

  // Sole requester wins; on a tie the port not served last wins
  function automatic int pick();
    if (req_v[0] && req_v[1]) return (last == 1) ? 0 : 1;
    if (req_v[0]) return 0;
    return 1;
  endfunction

  // One full transaction for port p, starting at a negedge in IDLE
  task automatic step(input int p, output logic [63:0] obs);
    logic        exp_err;
    logic        we;
    logic [63:0] a, d, exp_rd;
    apply();
    #1;
    chk("gnt0", 64'(bus.m0_gnt), 64'(p == 0));
    chk("gnt1", 64'(bus.m1_gnt), 64'(p == 1));
    we      = we_v[p];
    a       = addr_v[p];
    d       = wdata_v[p];
    exp_err = (a > LAST_OK);
    exp_rd  = (we || exp_err) ? 64'h0 : ref_read(a);
    @(negedge clk);
    req_v[p] = 1'b0;
    apply();
    #1;
    chk("acc_write", 64'(bus.mem_write), 64'(we && !exp_err));
    chk("acc_read",  64'(bus.mem_read),  64'(!we && !exp_err));
    chk("acc_gnt",   64'({bus.m0_gnt, bus.m1_gnt}), 64'h0);
    chk("acc_addr",  bus.mem_addr, a);
    if (we) chk("acc_wdata", bus.mem_wdata, d);
    if (we && !exp_err) ref_write(a, d);
    @(negedge clk);
    #1;
    chk("rsp_rvalid0", 64'(bus.m0_rvalid), 64'(p == 0));
    chk("rsp_rvalid1", 64'(bus.m1_rvalid), 64'(p == 1));
    obs = (p == 0) ? bus.m0_rdata : bus.m1_rdata;
    chk("rsp_rdata", obs, exp_rd);
    chk("rsp_err", 64'((p == 0) ? bus.m0_err : bus.m1_err), 64'(exp_err));
    chk("rsp_other_err", 64'((p == 0) ? bus.m1_err : bus.m0_err), 64'h0);
    chk("rsp_quiet", 64'({bus.m0_gnt, bus.m1_gnt, bus.mem_write, bus.mem_read}), 64'h0);
    last = p;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  logic [63:0] obs;
  int          diffs;

  initial begin
    n_err = 0;
    n_checks = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h00;
    ref_mem[0]  = 8'h03;
    ref_mem[16] = 8'h09;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
    end
    rst_n = 1'b0;
    apply();

    // Reset values, with a request held to confirm no grant during reset
    repeat (2) @(negedge clk);
    req_v[0] = 1'b1;
    apply();
    #1;
    chk("rst_gnt",    64'({bus.m0_gnt, bus.m1_gnt}), 64'h0);
    chk("rst_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}), 64'h0);
    chk("rst_strobe", 64'({bus.mem_write, bus.mem_read}), 64'h0);
    chk("rst_addr",   bus.mem_addr, 64'h0);
    chk("rst_wdata",  bus.mem_wdata, 64'h0);
    chk("rst_rdata0", bus.m0_rdata, 64'h0);
    chk("rst_rdata1", bus.m1_rdata, 64'h0);
    req_v[0] = 1'b0;
    apply();

    // Both ports requesting reads of addr 0 continuously from reset
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b0, 64'h0, 64'h0);
    set_req(1, 1'b0, 64'h0, 64'h0);
    apply();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("rr_gnt0_c%0d", k), 64'(bus.m0_gnt), 64'(k % 6 == 0));
      chk($sformatf("rr_gnt1_c%0d", k), 64'(bus.m1_gnt), 64'(k % 6 == 3));
      chk($sformatf("rr_rv0_c%0d", k), 64'(bus.m0_rvalid), 64'(k % 6 == 2));
      chk($sformatf("rr_rv1_c%0d", k), 64'(bus.m1_rvalid), 64'(k % 6 == 5));
      if (k % 3 == 2) chk($sformatf("rr_rdata_c%0d", k), bus.m0_rdata, 64'h3);
    end
    @(negedge clk);
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    apply();
    last = 1;

    // Preloaded read
    set_req(0, 1'b0, 64'h0, 64'h0);
    step(pick(), obs);
    chk("read0_const", obs, 64'h3);

    // Write from port 1 then read back from port 0
    set_req(1, 1'b1, 64'd8, 64'h1122334455667788);
    step(pick(), obs);
    chk("wr8_rdata_zero", obs, 64'h0);
    set_req(0, 1'b0, 64'd8, 64'h0);
    step(pick(), obs);
    chk("rd8_const", obs, 64'h1122334455667788);

    // Out-of-range pair, requested together
    set_req(0, 1'b0, 64'd57, 64'h0);
    set_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D);
    step(pick(), obs);
    step(pick(), obs);

    // Reset during the ACCESS cycle of a port-1 write to addr 16
    set_req(1, 1'b1, 64'd16, 64'h5555_6666_7777_8888);
    apply();
    #1;
    chk("abort_gnt1", 64'(bus.m1_gnt), 64'h1);
    @(negedge clk);
    req_v[1] = 1'b0;
    apply();
    #1;
    chk("abort_acc_write", 64'(bus.mem_write), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_write_drop", 64'(bus.mem_write), 64'h0);
    @(negedge clk);
    #1;
    chk("abort_no_rvalid", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'h0);
    chk("abort_byte16", 64'(mem[16]), 64'h9);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_no_rvalid2", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'h0);
    last = 1;
    set_req(1, 1'b0, 64'd16, 64'h0);
    step(pick(), obs);

    // Misaligned write then aligned read of the overlapped doubleword
    set_req(0, 1'b1, 64'd3, 64'hAABB);
    step(pick(), obs);
    set_req(0, 1'b0, 64'd0, 64'h0);
    step(pick(), obs);
    chk("misaligned_const", obs, 64'h000000AABB000003);

    // Randomized traffic, including ties and range boundaries
    for (int n = 0; n < 40; n++) begin
      int mask;
      mask = int'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          logic [63:0] a;
          int sel;
          sel = int'($urandom_range(0, 9));
          if (sel == 0)      a = LAST_OK + 64'd1;
          else if (sel == 1) a = LAST_OK;
          else if (sel == 2) a = {1'b1, $urandom, 31'($urandom)};
          else               a = 64'($urandom_range(0, int'(MEM_BYTES) - 8));
          set_req(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end
      end
      while (req_v[0] || req_v[1]) step(pick(), obs);
    end

    // Memory contents must match the reference exactly
    diffs = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_final_diffs", 64'(diffs), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
